// File: rtl/linear_layer_start_fifo_srl_ctrl.sv
// Shift-register FIFO controller: a DEPTH-entry SRL addressed by occupancy, with registered empty/full flags.
// Optional START_FIFO_OCCUPANCY_EN adds if_num_data_valid and if_fifo_cap.
module linear_layer_start_fifo_srl_ctrl #(
   parameter int DATA_WIDTH = 1,
   parameter int ADDR_WIDTH = 3,
   parameter int DEPTH      = 6
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst_n,
   input  logic                  if_write_ce,
   input  logic                  if_write,
   input  logic [DATA_WIDTH-1:0] if_din,
   output logic                  if_full_n,
   input  logic                  if_read_ce,
   input  logic                  if_read,
   output logic [DATA_WIDTH-1:0] if_dout,
   output logic                  if_empty_n
`ifdef START_FIFO_OCCUPANCY_EN
   ,
   output logic [ADDR_WIDTH:0]   if_num_data_valid,
   output logic [ADDR_WIDTH:0]   if_fifo_cap
`endif
);

   localparam int                  CW      = ADDR_WIDTH + 1;
   localparam logic [ADDR_WIDTH:0] DEPTH_C = CW'(DEPTH);
   localparam logic [ADDR_WIDTH:0] ONE_C   = CW'(1);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH:0]   count_reg;
   logic [ADDR_WIDTH:0]   count_next;
   logic                  empty_n_reg;
   logic                  empty_n_next;
   logic                  full_n_reg;
   logic                  full_n_next;
   logic                  push;
   logic                  pop;
   logic [ADDR_WIDTH-1:0] raddr;

   // Qualifying with the registered flags keeps inputs off any output path.
   assign push = if_write_ce & if_write & full_n_reg;
   assign pop  = if_read_ce & if_read & empty_n_reg;

   always_comb begin
      count_next   = count_reg;
      empty_n_next = empty_n_reg;
      full_n_next  = full_n_reg;
      if (push && !pop) begin
         count_next   = count_reg + ONE_C;
         empty_n_next = 1'b1;
         full_n_next  = (count_next != DEPTH_C);
      end else if (pop && !push) begin
         count_next   = count_reg - ONE_C;
         full_n_next  = 1'b1;
         empty_n_next = (count_next != '0);
      end
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         count_reg   <= '0;
         empty_n_reg <= 1'b0;
         full_n_reg  <= 1'b1;
      end else begin
         count_reg   <= count_next;
         empty_n_reg <= empty_n_next;
         full_n_reg  <= full_n_next;
      end
   end

   // Storage is deliberately unreset so it maps onto SRL primitives.
   always_ff @(posedge ap_clk) begin
      if (push) begin
         mem[0] <= if_din;
         for (int i = 1; i < DEPTH; i++) begin
            mem[i] <= mem[i-1];
         end
      end
   end

   always_comb begin
      raddr = '0;
      if (count_reg != '0) begin
         raddr = ADDR_WIDTH'(count_reg - ONE_C);
      end
   end

   assign if_dout    = mem[raddr];
   assign if_empty_n = empty_n_reg;
   assign if_full_n  = full_n_reg;

`ifdef START_FIFO_OCCUPANCY_EN
   assign if_num_data_valid = count_reg;
   assign if_fifo_cap       = DEPTH_C;
`endif

   a_count_bound : assert property (@(posedge ap_clk) disable iff (!ap_rst_n)
      count_reg <= DEPTH_C);
   a_empty_flag : assert property (@(posedge ap_clk) disable iff (!ap_rst_n)
      empty_n_reg == (count_reg != '0));
   a_full_flag : assert property (@(posedge ap_clk) disable iff (!ap_rst_n)
      full_n_reg == (count_reg != DEPTH_C));

endmodule
